// File: rtl/axis_weighted_scaler.sv
// axis_weighted_scaler: AXI-Stream per-lane signed scaler.
// Each lane is multiplied by a per-packet Q1.(WEIGHT_WIDTH-1) weight and
// rounded half-up. The result then goes through a two-stage pipeline that
// preserves the beat order.
// Optional build macro: AXIS_SCALER_SAT_EN. When it is defined, results
// outside the sample range clamp to the limits. When it is not defined,
// results wrap to SAMPLE_WIDTH bits.
module axis_weighted_scaler #(
    parameter int LANES        = 16,
    parameter int SAMPLE_WIDTH = 8,
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [LANES*SAMPLE_WIDTH-1:0]   s_axis_tdata,
    input  logic [LANES*SAMPLE_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    input  logic [WEIGHT_WIDTH-1:0]         weight,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [LANES*SAMPLE_WIDTH-1:0]   m_axis_tdata,
    output logic [LANES*SAMPLE_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic [15:0]                     pkt_count
);

    localparam int DW  = LANES * SAMPLE_WIDTH;
    localparam int KW  = DW / 8;
    localparam int BPL = SAMPLE_WIDTH / 8;
    localparam int PW  = SAMPLE_WIDTH + WEIGHT_WIDTH + 1;
    localparam int SH  = WEIGHT_WIDTH - 1;
    // Half of one output LSB; adding it before the shift gives round-half-up.
    localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (WEIGHT_WIDTH - 2);
`ifdef AXIS_SCALER_SAT_EN
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [0:0] {
        ST_FIRST = 1'b0,
        ST_BODY  = 1'b1
    } state_t;

    // Full-precision signed sample times unsigned weight.
    function automatic logic signed [PW-1:0] lane_mul(
        input logic [SAMPLE_WIDTH-1:0] s,
        input logic [WEIGHT_WIDTH-1:0] w
    );
        logic signed [PW-1:0] s_ext;
        logic signed [PW-1:0] w_ext;
        s_ext = {{(PW-SAMPLE_WIDTH){s[SAMPLE_WIDTH-1]}}, s};
        w_ext = {{(PW-WEIGHT_WIDTH){1'b0}}, w};
        return s_ext * w_ext;
    endfunction

    // Round half up, drop the fraction, then clamp or wrap to sample width.
    function automatic logic [SAMPLE_WIDTH-1:0] lane_round(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        r = (p + RND) >>> SH;
`ifdef AXIS_SCALER_SAT_EN
        if (r > SAT_MAX) begin
            return SAT_MAX[SAMPLE_WIDTH-1:0];
        end else if (r < SAT_MIN) begin
            return SAT_MIN[SAMPLE_WIDTH-1:0];
        end else begin
            return r[SAMPLE_WIDTH-1:0];
        end
`else
        return r[SAMPLE_WIDTH-1:0];
`endif
    endfunction

    state_t                          state_q, state_d;
    logic [WEIGHT_WIDTH-1:0]         weight_q, weight_d;
    logic                            s1_valid_q, s1_valid_d;
    logic [LANES-1:0][PW-1:0]        s1_prod_q, s1_prod_d;
    logic [KW-1:0]                   s1_keep_q, s1_keep_d;
    logic                            s1_last_q, s1_last_d;
    logic                            m_valid_q, m_valid_d;
    logic [DW-1:0]                   m_data_q, m_data_d;
    logic [KW-1:0]                   m_keep_q, m_keep_d;
    logic                            m_last_q, m_last_d;
    logic [15:0]                     pkt_count_q, pkt_count_d;

    logic                            advance_s;
    logic                            ready_s;
    logic                            in_fire_s;
    logic                            out_fire_s;
    logic [WEIGHT_WIDTH-1:0]         eff_weight_s;

    // Handshake qualifiers, next-state, and datapath for both pipeline stages.
    always_comb begin
        advance_s    = !m_valid_q || m_axis_tready;
        ready_s      = advance_s && !reset;
        in_fire_s    = s_axis_tvalid && ready_s;
        out_fire_s   = m_valid_q && m_axis_tready;
        // The first beat uses the live port; later beats use the captured weight.
        eff_weight_s = (state_q == ST_FIRST) ? weight : weight_q;

        state_d     = state_q;
        weight_d    = weight_q;
        s1_valid_d  = s1_valid_q;
        s1_prod_d   = s1_prod_q;
        s1_keep_d   = s1_keep_q;
        s1_last_d   = s1_last_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        pkt_count_d = pkt_count_q;

        if (in_fire_s) begin
            case (state_q)
                ST_FIRST: begin
                    weight_d = weight;
                    state_d  = s_axis_tlast ? ST_FIRST : ST_BODY;
                end
                ST_BODY: begin
                    weight_d = weight_q;
                    state_d  = s_axis_tlast ? ST_FIRST : ST_BODY;
                end
                default: begin
                    weight_d = weight_q;
                    state_d  = ST_FIRST;
                end
            endcase
        end else begin
            state_d  = state_q;
            weight_d = weight_q;
        end

        if (advance_s) begin
            s1_valid_d = in_fire_s;
            s1_keep_d  = s_axis_tkeep;
            s1_last_d  = s_axis_tlast;
            for (int k = 0; k < LANES; k++) begin
                s1_prod_d[k] = lane_mul(s_axis_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH], eff_weight_s);
            end
            m_valid_d = s1_valid_q;
            m_keep_d  = s1_keep_q;
            m_last_d  = s1_last_q;
            for (int k = 0; k < LANES; k++) begin
                if (|s1_keep_q[k*BPL +: BPL]) begin
                    m_data_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = lane_round(s1_prod_q[k]);
                end else begin
                    m_data_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = {SAMPLE_WIDTH{1'b0}};
                end
            end
        end else begin
            s1_valid_d = s1_valid_q;
            m_valid_d  = m_valid_q;
        end

        if (out_fire_s && m_last_q) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end else begin
            pkt_count_d = pkt_count_q;
        end
    end

    // Packet FSM, captured weight, and pipeline registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= ST_FIRST;
            weight_q    <= {WEIGHT_WIDTH{1'b0}};
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= '0;
            s1_keep_q   <= {KW{1'b0}};
            s1_last_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= {DW{1'b0}};
            m_keep_q    <= {KW{1'b0}};
            m_last_q    <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            weight_q    <= weight_d;
            s1_valid_q  <= s1_valid_d;
            s1_prod_q   <= s1_prod_d;
            s1_keep_q   <= s1_keep_d;
            s1_last_q   <= s1_last_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign s_axis_tready = ready_s;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_weighted_scaler.sv
// Directed testbench for axis_weighted_scaler at default parameters.
module tb_axis_weighted_scaler;

    localparam int LANES = 16;
    localparam int SW    = 8;
    localparam int WW    = 8;
    localparam int DW    = LANES * SW;
    localparam int KW    = DW / 8;

    logic          CLK = 1'b0;
    logic          reset;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic [WW-1:0] weight;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [15:0]   pkt_count;

    axis_weighted_scaler dut (
        .CLK           (CLK),
        .reset         (reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .weight        (weight),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_count     (pkt_count)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] in_data   [32];
    logic [KW-1:0] in_keep   [32];
    logic          in_last   [32];
    logic [WW-1:0] in_weight [32];
    logic [DW-1:0] out_data  [32];
    logic [KW-1:0] out_keep  [32];
    logic          out_last  [32];
    int            out_cyc   [32];
    int            out_n;
    int            rdy_err;
    int            stall_cnt;

    // Drives n_in beats from the input tables and collects output beats.
    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic run_stream(input int n_in, input logic [3:0] rdy_pat);
        int idx;
        int cyc;
        idx = 0; cyc = 0; out_n = 0; rdy_err = 0; stall_cnt = 0;
        while (out_n < n_in && cyc < 200) begin
            if (idx < n_in) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = in_data[idx];
                s_axis_tkeep  = in_keep[idx];
                s_axis_tlast  = in_last[idx];
                weight        = in_weight[idx];
            end else begin
                s_axis_tvalid = 1'b0;
            end
            m_axis_tready = rdy_pat[cyc[1:0]];
            #1;
            if (s_axis_tready !== (!m_axis_tvalid || m_axis_tready)) rdy_err++;
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b0) stall_cnt++;
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1 && out_n < 32) begin
                out_data[out_n] = m_axis_tdata;
                out_keep[out_n] = m_axis_tkeep;
                out_last[out_n] = m_axis_tlast;
                out_cyc[out_n]  = cyc;
                out_n++;
            end
            if (s_axis_tvalid === 1'b1 && s_axis_tready === 1'b1) idx++;
            @(posedge CLK); #1;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = {DW{1'b1}};
        s_axis_tkeep = {KW{1'b1}}; s_axis_tlast = 1'b1; weight = 8'h80; m_axis_tready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
        total++; if (m_axis_tdata !== {DW{1'b0}}) begin bad++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
        total++; if (m_axis_tkeep !== {KW{1'b0}}) begin bad++; $display("FAIL reset_tkeep got=%h exp=0", m_axis_tkeep); end
        total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
        total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b exp=0", s_axis_tready); end
        reset = 1'b0; s_axis_tvalid = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_half_scale();
        logic [DW-1:0] exp_d;
        in_data[0] = {LANES{8'h64}}; in_keep[0] = {KW{1'b1}}; in_last[0] = 1'b1; in_weight[0] = 8'h40;
        exp_d = {LANES{8'h32}};
        run_stream(1, 4'b1111);
        total++; if (out_n !== 1) begin bad++; $display("FAIL half_count got=%0d exp=1", out_n); end
        total++; if (out_data[0] !== exp_d) begin bad++; $display("FAIL half_data got=%h exp=%h", out_data[0], exp_d); end
        total++; if (out_cyc[0] !== 2) begin bad++; $display("FAIL half_latency got=%0d exp=2", out_cyc[0]); end
        total++; if (out_last[0] !== 1'b1 || out_keep[0] !== {KW{1'b1}}) begin
            bad++; $display("FAIL half_side got=%b/%h exp=1/ffff", out_last[0], out_keep[0]);
        end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL half_pkt_count got=%0d exp=1", pkt_count); end
    endtask

    task automatic test_limit();
        logic [31:0]   grp_in;
        logic [31:0]   grp_exp;
        logic [DW-1:0] exp_d;
        grp_in = {8'hFF, 8'h01, 8'h80, 8'h7F};
`ifdef AXIS_SCALER_SAT_EN
        grp_exp = {8'hFE, 8'h02, 8'h80, 8'h7F};
`else
        grp_exp = {8'hFE, 8'h02, 8'h01, 8'hFD};
`endif
        in_data[0] = {4{grp_in}}; in_keep[0] = {KW{1'b1}}; in_last[0] = 1'b1; in_weight[0] = 8'hFF;
        exp_d = {4{grp_exp}};
        run_stream(1, 4'b1111);
        total++; if (out_data[0] !== exp_d) begin bad++; $display("FAIL limit_data got=%h exp=%h", out_data[0], exp_d); end
        total++; if (pkt_count !== 16'd2) begin bad++; $display("FAIL limit_pkt_count got=%0d exp=2", pkt_count); end
    endtask

    task automatic test_weight_hold();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < LANES; k++) in_data[i][k*8 +: 8] = 8'(i * 37 + k * 11 + 3);
            in_keep[i] = {KW{1'b1}};
            in_last[i] = (i == 3);
            in_weight[i] = (i == 0) ? 8'h80 : 8'h00;
        end
        run_stream(4, 4'b1111);
        total++; if (out_n !== 4) begin bad++; $display("FAIL hold_count got=%0d exp=4", out_n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_data[i] !== in_data[i] || out_last[i] !== (i == 3)) begin
                bad++; $display("FAIL hold_beat%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i], in_data[i], (i == 3));
            end
        end
        total++; if (pkt_count !== 16'd3) begin bad++; $display("FAIL hold_pkt_count got=%0d exp=3", pkt_count); end
    endtask

    task automatic test_back_to_back_stall();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < LANES; k++) in_data[i][k*8 +: 8] = 8'(i * 29 + k * 7 + 1);
            in_keep[i] = {KW{1'b1}};
            in_last[i] = (i == 7);
            in_weight[i] = (i == 0) ? 8'h80 : 8'h33;
        end
        run_stream(8, 4'b1001);
        total++; if (out_n !== 8) begin bad++; $display("FAIL stall_count got=%0d exp=8", out_n); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (out_data[i] !== in_data[i] || out_last[i] !== (i == 7)) begin
                bad++; $display("FAIL stall_beat%0d got=%h exp=%h", i, out_data[i], in_data[i]);
            end
        end
        total++; if (rdy_err !== 0) begin bad++; $display("FAIL stall_tready got=%0d exp=0 bad cycles", rdy_err); end
        total++; if (stall_cnt < 1) begin bad++; $display("FAIL stall_seen got=%0d exp=>0", stall_cnt); end
        total++; if (pkt_count !== 16'd4) begin bad++; $display("FAIL stall_pkt_count got=%0d exp=4", pkt_count); end
    endtask

    task automatic test_keep();
        logic [DW-1:0] exp_d;
        in_data[0] = {LANES{8'h10}}; in_keep[0] = 16'h00FF; in_last[0] = 1'b1; in_weight[0] = 8'h80;
        exp_d = {{8{8'h00}}, {8{8'h10}}};
        run_stream(1, 4'b1111);
        total++; if (out_data[0] !== exp_d) begin bad++; $display("FAIL keep_data got=%h exp=%h", out_data[0], exp_d); end
        total++; if (out_keep[0] !== 16'h00FF) begin bad++; $display("FAIL keep_tkeep got=%h exp=00ff", out_keep[0]); end
        total++; if (pkt_count !== 16'd5) begin bad++; $display("FAIL keep_pkt_count got=%0d exp=5", pkt_count); end
    endtask

    task automatic test_reset_mid_packet();
        logic [DW-1:0] exp_d;
        int acc;
        acc = 0;
        s_axis_tvalid = 1'b1; s_axis_tdata = {LANES{8'h20}}; s_axis_tkeep = {KW{1'b1}};
        s_axis_tlast = 1'b0; weight = 8'h40; m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (s_axis_tready === 1'b1) acc++;
            @(posedge CLK); #1;
            weight = 8'h00;
        end
        total++; if (acc !== 3) begin bad++; $display("FAIL mid_accepts got=%0d exp=3", acc); end
        reset = 1'b1; s_axis_tvalid = 1'b0;
        #1;
        total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL mid_tready got=%b exp=0", s_axis_tready); end
        @(posedge CLK); #1;
        reset = 1'b0;
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL mid_tvalid got=%b exp=0", m_axis_tvalid); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL mid_pkt_count got=%0d exp=0", pkt_count); end
        in_data[0] = {LANES{8'h20}}; in_keep[0] = {KW{1'b1}}; in_last[0] = 1'b1; in_weight[0] = 8'h80;
        exp_d = {LANES{8'h20}};
        run_stream(1, 4'b1111);
        total++; if (out_data[0] !== exp_d) begin bad++; $display("FAIL mid_newpkt got=%h exp=%h", out_data[0], exp_d); end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL mid_pkt_after got=%0d exp=1", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_half_scale();
        test_limit();
        test_weight_hold();
        test_back_to_back_stall();
        test_keep();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_weighted_scaler.md
AXIS_WEIGHTED_SCALER -- requirements
Module: axis_weighted_scaler

Interface
REQ-001 SHALL have parameter LANES, default 16: samples per beat.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 8: signed two's-complement bits per sample.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8: unsigned weight bits, format Q1.(WEIGHT_WIDTH-1), range [0,2).
REQ-004 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_axis_tvalid  input  1  upstream beat valid.
REQ-007 SHALL have port s_axis_tready  output  1  block accepts beat.
REQ-008 SHALL have port s_axis_tdata  input  LANES*SAMPLE_WIDTH  samples; lane k at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-009 SHALL have port s_axis_tkeep  input  LANES*SAMPLE_WIDTH/8  byte enables.
REQ-010 SHALL have port s_axis_tlast  input  1  last beat of packet.
REQ-011 SHALL have port weight  input  WEIGHT_WIDTH  scale factor, sampled per packet.
REQ-012 SHALL have port m_axis_tvalid  output  1  output beat valid.
REQ-013 SHALL have port m_axis_tready  input  1  downstream accepts beat.
REQ-014 SHALL have port m_axis_tdata  output  LANES*SAMPLE_WIDTH  scaled samples.
REQ-015 SHALL have port m_axis_tkeep  output  LANES*SAMPLE_WIDTH/8  tkeep of the same beat.
REQ-016 SHALL have port m_axis_tlast  output  1  tlast of the same beat.
REQ-017 SHALL have port pkt_count  output  16  packets completed at output, wraps 0xFFFF->0.

Function
REQ-018 Transfer occurs only on a cycle with tvalid and tready both high on that interface.
REQ-019 Datapath SHALL be a 2-stage pipeline (S1: multiply, S2: round/limit/register); latency SHALL be 2 cycles from input handshake to m_axis_tvalid, throughput 1 beat/cycle.
REQ-020 Pipeline SHALL advance when !m_axis_tvalid or m_axis_tready; s_axis_tready SHALL equal this advance condition; no beat SHALL be dropped or duplicated under any tready pattern.
REQ-021 Packet FSM SHALL have states FIRST (next accepted beat starts a packet) and BODY; FIRST->BODY on accepted beat with tlast=0; BODY->FIRST on accepted beat with tlast=1; FIRST stays FIRST on accepted single-beat packet (tlast=1).
REQ-022 Weight SHALL be captured from port weight on the accepted beat in FIRST and used for every beat of that packet; weight changes mid-packet SHALL have no effect.
REQ-023 Per lane: p = s * w (full precision, SAMPLE_WIDTH+WEIGHT_WIDTH+1 bits signed); r = (p + 2^(WEIGHT_WIDTH-2)) arithmetic-shifted right by WEIGHT_WIDTH-1 (round half up).
REQ-024 Lanes whose bytes in tkeep are all 0 SHALL output zero data; tkeep and tlast SHALL pass unmodified alongside data.
REQ-025 pkt_count SHALL increment by 1 on each output handshake with m_axis_tlast=1.

Reset
REQ-026 While reset is high at a clock edge: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, pkt_count=0, FSM=FIRST, captured weight=0, all pipeline valids=0.
REQ-027 s_axis_tready SHALL be 0 while reset is high.
REQ-028 Reset mid-packet SHALL discard all in-flight beats; first beat accepted after reset starts a new packet.

Configuration
REQ-029 Macro AXIS_SCALER_SAT_EN defined: r outside [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1] SHALL clamp to the nearest limit.
REQ-030 Macro AXIS_SCALER_SAT_EN undefined: output SHALL be the low SAMPLE_WIDTH bits of r (wrap); latency unchanged.

Verification
REQ-031 Defaults, weight=0x40 (0.5), all lanes 0x64 (100), tkeep all 1, tlast=1 -> all lanes 0x32 two cycles later, pkt_count=1.
REQ-032 weight=0xFF, lane=127 -> r=253; SAT_EN: 0x7F; no SAT_EN: 0xFD. lane=-128 -> SAT_EN 0x80.
REQ-033 weight=0x80 on beat 0 of 4-beat packet, weight=0x00 on beats 1-3 -> all 4 output beats equal input (unity).
REQ-034 m_axis_tready toggling 1,0,0,1 with continuous input of 8 beats -> all 8 beats out in order, none lost, s_axis_tready low exactly while stalled.
REQ-035 tkeep=0x00FF, all lanes 0x10, weight=0x80 -> lanes 0-7 = 0x10, lanes 8-15 = 0x00, m_axis_tkeep=0x00FF.
REQ-036 reset asserted for 1 cycle after beat 2 of 5-beat packet -> m_axis_tvalid=0 next cycle, pkt_count=0, next packet uses its own first-beat weight.
